// File: rtl/fifo_stream_pkg.sv
// Shared types and default geometry for the read-side pixel stream.
package fifo_stream_pkg;

  localparam int unsigned DEF_DATA_WD = 8;
  localparam int unsigned DEF_IMG_W   = 640;
  localparam int unsigned DEF_IMG_H   = 480;
  localparam int unsigned DEF_COL_WD  = 10;
  localparam int unsigned DEF_ROW_WD  = 9;

  typedef logic [DEF_DATA_WD-1:0] pix_t;
  typedef logic [DEF_COL_WD-1:0]  col_t;
  typedef logic [DEF_ROW_WD-1:0]  row_t;

  typedef struct packed {
    pix_t data;
    logic sof;
    logic eol;
    logic eof;
  } stream_beat_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer: simultaneous write and pop, synchronous clear.
module skid_buf2 #(
  parameter int unsigned DATA_WD = 8
) (
  input  logic               r_clk_i,
  input  logic               r_rst_ni,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [DATA_WD-1:0] wdata_i,
  input  logic               pop_i,
  output logic [1:0]         occ_o,
  output logic [DATA_WD-1:0] head_o
);

  logic [DATA_WD-1:0] e0_q, e1_q;
  logic [1:0]         occ_q, occ_d;

  always_comb begin
    occ_d = occ_q + {1'b0, wr_i} - {1'b0, pop_i};
  end

  always_ff @(posedge r_clk_i or negedge r_rst_ni) begin
    if (!r_rst_ni) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else if (clr_i) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
      if (pop_i) begin
        // e0 is always the head; a pop shifts e1 forward when it is live
        if (occ_q == 2'd2) begin
          e0_q <= e1_q;
          if (wr_i) e1_q <= wdata_i;
        end else if (wr_i) begin
          e0_q <= wdata_i;
        end
      end else if (wr_i) begin
        if (occ_q == 2'd0) e0_q <= wdata_i;
        else               e1_q <= wdata_i;
      end
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

  occ_max_a: assert property (@(posedge r_clk_i) disable iff (!r_rst_ni) occ_q <= 2'd2);
  no_ovf_a:  assert property (@(posedge r_clk_i) disable iff (!r_rst_ni)
                              !(wr_i && !pop_i && !clr_i && occ_q == 2'd2));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the async pixel FIFO read port into a tagged valid/ready pixel stream.
// Define STALL_CNT_EN to add the stall_cnt_o starvation counter.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WD = DEF_DATA_WD,
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned COL_WD  = DEF_COL_WD,
  parameter int unsigned ROW_WD  = DEF_ROW_WD
) (
  input  logic               r_clk_i,
  input  logic               r_rst_ni,
  input  logic               sclr_i,
  input  logic               fifo_empty_i,
  input  logic [DATA_WD-1:0] fifo_rdata_i,
  output logic               fifo_r_en_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [DATA_WD-1:0] m_data_o,
  output logic               m_sof_o,
  output logic               m_eol_o,
  output logic               m_eof_o,
  output logic [COL_WD-1:0]  col_o,
  output logic [ROW_WD-1:0]  row_o
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt_o
`endif
);

  localparam logic [COL_WD-1:0] ColLast = COL_WD'(IMG_W - 1);
  localparam logic [ROW_WD-1:0] RowLast = ROW_WD'(IMG_H - 1);

  logic              pop, wr, inflight_q, r_en_core;
  logic [1:0]        occ;
  logic [2:0]        pend;
  logic [COL_WD-1:0] col_q;
  logic [ROW_WD-1:0] row_q;

  assign pop  = m_valid_o & m_ready_i;
  // Buffered plus in-flight words after this cycle's pop must fit in two entries
  assign pend = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign r_en_core   = ~sclr_i & ~fifo_empty_i & (pend < 3'd2);
  assign fifo_r_en_o = r_en_core & r_rst_ni;
  // A word landing during sclr belongs to the abandoned frame
  assign wr = inflight_q & ~sclr_i;

  always_ff @(posedge r_clk_i or negedge r_rst_ni) begin
    if (!r_rst_ni) inflight_q <= 1'b0;
    else           inflight_q <= r_en_core;
  end

  skid_buf2 #(
    .DATA_WD(DATA_WD)
  ) u_buf (
    .r_clk_i (r_clk_i),
    .r_rst_ni(r_rst_ni),
    .clr_i   (sclr_i),
    .wr_i    (wr),
    .wdata_i (fifo_rdata_i),
    .pop_i   (pop & ~sclr_i),
    .occ_o   (occ),
    .head_o  (m_data_o)
  );

  always_ff @(posedge r_clk_i or negedge r_rst_ni) begin
    if (!r_rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else if (sclr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pop) begin
      if (col_q == ColLast) begin
        col_q <= '0;
        row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign m_valid_o = (occ != 2'd0);
  assign m_sof_o   = m_valid_o & (col_q == '0) & (row_q == '0);
  assign m_eol_o   = m_valid_o & (col_q == ColLast);
  assign m_eof_o   = m_eol_o & (row_q == RowLast);
  assign col_o     = col_q;
  assign row_o     = row_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge r_clk_i or negedge r_rst_ni) begin
    if (!r_rst_ni) begin
      stall_q <= '0;
    end else if (sclr_i) begin
      stall_q <= '0;
    end else if (m_ready_i && !m_valid_o && (col_q != '0 || row_q != '0) &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
